// File: rtl/load_mem_stage_pkg.sv
// rtl/load_mem_stage_pkg.sv - shared types and widths for the load memory-access stage
// Holds the MEM_SIZE and LD_STATE enums and the captured load request packet.
package load_mem_stage_pkg;

  localparam int XLEN      = 32;
  localparam int LQ_IDX_W  = 3;
  localparam int ROB_IDX_W = 5;
  localparam int PREG_W    = 6;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [2:0] {
    LD_IDLE     = 3'd0,
    LD_CHECK    = 3'd1,
    LD_MEM_REQ  = 3'd2,
    LD_MEM_WAIT = 3'd3,
    LD_WB       = 3'd4,
    LD_DRAIN    = 3'd5
  } ld_state_e;

  typedef struct packed {
    logic [LQ_IDX_W-1:0]  lq_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    dest;
    logic [XLEN-1:0]      addr;
    mem_size_e            size;
    logic                 is_unsigned;
  } load_req_packet_t;

  // Halves must sit on even bytes and words on word boundaries.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'd0);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational byte/half/word extraction with sign or zero extension
// Also reused by the SQ forward path, so it stays free of any stage state.
module load_align
  import load_mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  mem_size_e       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;
  logic            sign_fill;

  always_comb begin
    shifted   = word >> {off, 3'b000};
    sign_fill = 1'b0;
    value     = shifted;
    case (size)
      MEM_BYTE: begin
        sign_fill = ~is_unsigned & shifted[7];
        value     = {{(XLEN-8){sign_fill}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sign_fill = ~is_unsigned & shifted[15];
        value     = {{(XLEN-16){sign_fill}}, shifted[15:0]};
      end
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/load_mem_stage.sv
// rtl/load_mem_stage.sv - load memory stage: SQ check, forward or D-cache read, align, CDB writeback
// Optional LOAD_FWD_EN enables store-to-load forwarding; otherwise a forward hit stalls like a block.
module load_mem_stage
  import load_mem_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lq_req_valid,
  output logic                 lq_req_ready,
  input  logic [LQ_IDX_W-1:0]  lq_req_lq_idx,
  input  logic [ROB_IDX_W-1:0] lq_req_rob_idx,
  input  logic [PREG_W-1:0]    lq_req_dest,
  input  logic [XLEN-1:0]      lq_req_addr,
  input  logic [1:0]           lq_req_size,
  input  logic                 lq_req_unsigned,
  output logic [XLEN-1:0]      sq_query_addr,
  output logic [1:0]           sq_query_size,
  output logic [LQ_IDX_W-1:0]  sq_query_lq_idx,
  input  logic                 sq_block,
  input  logic                 sq_fwd_hit,
  input  logic [XLEN-1:0]      sq_fwd_data,
  output logic                 dc_req_valid,
  output logic [XLEN-1:0]      dc_req_addr,
  input  logic                 dc_req_ready,
  input  logic                 dc_rsp_valid,
  input  logic [XLEN-1:0]      dc_rsp_data,
  output logic                 cdb_req_valid,
  input  logic                 cdb_grant,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [PREG_W-1:0]    cdb_dest,
  output logic [XLEN-1:0]      cdb_value,
  output logic                 lq_done_valid,
  output logic [LQ_IDX_W-1:0]  lq_done_idx,
  input  logic                 squash,
  output logic                 busy
);

  ld_state_e        state;
  load_req_packet_t hold;
  load_req_packet_t req_pkt;
  logic [XLEN-1:0]  word_in;
  logic [XLEN-1:0]  aligned;
  logic             sq_stall;
  logic             fwd_take;

  always_comb begin
    req_pkt.lq_idx      = lq_req_lq_idx;
    req_pkt.rob_idx     = lq_req_rob_idx;
    req_pkt.dest        = lq_req_dest;
    req_pkt.addr        = lq_req_addr;
    req_pkt.size        = mem_size_e'(lq_req_size);
    req_pkt.is_unsigned = lq_req_unsigned;
  end

`ifdef LOAD_FWD_EN
  assign sq_stall = sq_block;
  assign fwd_take = sq_fwd_hit;
  assign word_in  = (state == LD_CHECK) ? sq_fwd_data : dc_rsp_data;
`else
  // Without forwarding a covering store is simply waited out until it retires.
  logic unused_fwd_data;
  assign sq_stall        = sq_block | sq_fwd_hit;
  assign fwd_take        = 1'b0;
  assign word_in         = dc_rsp_data;
  assign unused_fwd_data = ^sq_fwd_data;
`endif

  load_align u_align (
    .word        (word_in),
    .off         (hold.addr[1:0]),
    .size        (hold.size),
    .is_unsigned (hold.is_unsigned),
    .value       (aligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LD_IDLE;
      hold      <= '0;
      cdb_value <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (lq_req_valid && lq_req_ready) begin
            hold  <= req_pkt;
            state <= LD_CHECK;
          end
        end
        LD_CHECK: begin
          if (squash) begin
            state <= LD_IDLE;
          end else if (sq_stall) begin
            state <= LD_CHECK;
          end else if (fwd_take) begin
            cdb_value <= aligned;
            state     <= LD_WB;
          end else begin
            state <= LD_MEM_REQ;
          end
        end
        LD_MEM_REQ: begin
          // An accepted request still owes us a response, so a squash must drain it.
          if (dc_req_ready) begin
            state <= squash ? LD_DRAIN : LD_MEM_WAIT;
          end else if (squash) begin
            state <= LD_IDLE;
          end
        end
        LD_MEM_WAIT: begin
          if (dc_rsp_valid) begin
            if (squash) begin
              state <= LD_IDLE;
            end else begin
              cdb_value <= aligned;
              state     <= LD_WB;
            end
          end else if (squash) begin
            state <= LD_DRAIN;
          end
        end
        LD_WB: begin
          if (squash || cdb_grant) begin
            state <= LD_IDLE;
          end
        end
        LD_DRAIN: begin
          if (dc_rsp_valid) begin
            state <= LD_IDLE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign lq_req_ready    = (state == LD_IDLE) && !squash && !reset;
  assign busy            = (state != LD_IDLE);
  assign sq_query_addr   = hold.addr;
  assign sq_query_size   = hold.size;
  assign sq_query_lq_idx = hold.lq_idx;
  assign dc_req_valid    = (state == LD_MEM_REQ);
  assign dc_req_addr     = {hold.addr[XLEN-1:2], 2'b00};
  assign cdb_req_valid   = (state == LD_WB);
  assign cdb_rob_idx     = hold.rob_idx;
  assign cdb_dest        = hold.dest;
  // Squash wins over a same-cycle grant, so the done pulse is suppressed.
  assign lq_done_valid   = (state == LD_WB) && cdb_grant && !squash;
  assign lq_done_idx     = lq_done_valid ? hold.lq_idx : '0;

  a_aligned_req: assert property (@(posedge clock) disable iff (reset)
    (lq_req_valid && lq_req_ready) |-> !is_misaligned(lq_req_addr[1:0], lq_req_size));

endmodule
